// File: rtl/seg_pkg.sv
// Shared types and defaults for the seven-segment display arbiter.
//   state_e      : arbiter state (IDLE / OWN)
//   DEF_*        : default parameter values
//   HOLD_W       : width of the ownership hold counter
//   hold_cycles(): minimum ownership time in clock cycles
package seg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam int unsigned DEF_CLK_FREQ = 100_000_000;
  localparam int unsigned DEF_N_REQ    = 4;
  localparam int unsigned DEF_HOLD_MS  = 500;
  localparam int unsigned HOLD_W       = 32;

  // HOLD_MS milliseconds expressed in cycles of a CLK_FREQ Hz clock
  function automatic logic [HOLD_W-1:0] hold_cycles(input int unsigned clk_freq,
                                                    input int unsigned hold_ms);
    return HOLD_W'(hold_ms * (clk_freq / 1000));
  endfunction

endpackage

// File: rtl/seg_arbiter_if.sv
// Request/grant bundle between display sources and the arbiter.
//   req       : per-source level request
//   req_data  : source i's 8 hex digits on [32*i+31 -: 32]
//   grant     : one-hot current owner, zero when idle
//   owner     : index of the current or last owner
//   busy      : |grant
//   disp_data : word forwarded to the seven-segment scan driver
interface seg_arbiter_if import seg_pkg::*; #(
  parameter int unsigned N_REQ = DEF_N_REQ
);
  localparam int unsigned OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]    req;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    grant;
  logic [OWN_W-1:0]    owner;
  logic                busy;
  logic [31:0]         disp_data;

  modport master (
    output req, req_data,
    input  grant, owner, busy, disp_data
  );

  modport slave (
    input  req, req_data,
    output grant, owner, busy, disp_data
  );
endinterface

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : first index in the search order
//   excl  : indices to ignore (the current owner during a handover)
//   found : some non-excluded request is set
//   idx   : first such request searching ptr, ptr+1, ... mod N_REQ
module seg_rr_pick import seg_pkg::*; #(
  parameter int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned PW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  input  logic [N_REQ-1:0] excl,
  output logic             found,
  output logic [PW-1:0]    idx
);

  logic [N_REQ-1:0] cand;
  assign cand = req & ~excl;

  // Walk the search order backwards so the nearest candidate to ptr wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      int unsigned    pos;
      logic [PW-1:0]  pos_w;
      pos   = (32'(ptr) + k - 1) % N_REQ;
      pos_w = PW'(pos);
      if (cand[pos_w]) begin
        found = 1'b1;
        idx   = pos_w;
      end
    end
  end

endmodule

// File: rtl/seg_arbiter.sv
// Round-robin owner of the shared eight-digit seven-segment display.
// A source keeps the display for at least HOLD_CYC cycles under contention,
// may release it early, and is handed over without an idle cycle at expiry.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : slave side of seg_arbiter_if (req/req_data in, grant/owner/busy/disp_data out)
module seg_arbiter import seg_pkg::*; #(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned N_REQ    = DEF_N_REQ,
  parameter int unsigned HOLD_MS  = DEF_HOLD_MS
) (
  input  logic          CLK,
  input  logic          RST,
  seg_arbiter_if.slave  bus
);

  localparam int unsigned PW = $clog2(N_REQ);
  localparam logic [HOLD_W-1:0] HOLD_LAST = hold_cycles(CLK_FREQ, HOLD_MS) - HOLD_W'(1);

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [31:0]         data_q, data_d;
  logic                busy_q, busy_d;

  logic [31:0]         src_data [N_REQ];
  logic                pick_found;
  logic [PW-1:0]       pick_idx;
  logic [N_REQ-1:0]    pick_oh;
  logic [PW-1:0]       pick_next;

  // Per-source view of the packed data bus
  for (genvar i = 0; i < N_REQ; i++) begin : g_src
    assign src_data[i] = bus.req_data[32*i +: 32];
  end

  // grant_q masks out the current owner; it is zero while idle
  seg_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .excl  (grant_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // One-hot of the pick and the pointer position just past it
  always_comb begin
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
    pick_next         = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + PW'(1);
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWN;
          grant_d = pick_oh;
          owner_d = pick_idx;
          ptr_d   = pick_next;
          hold_d  = '0;
          data_d  = src_data[pick_idx];
        end
      end
      OWN: begin
        if (!bus.req[owner_q]) begin
          // early release; disp_data keeps the last shown word
          state_d = IDLE;
          grant_d = '0;
        end else if (hold_q < HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
          data_d = src_data[owner_q];
        end else if (pick_found) begin
          // direct handover: old grant falls and new rises on one edge
          grant_d = pick_oh;
          owner_d = pick_idx;
          ptr_d   = pick_next;
          hold_d  = '0;
          data_d  = src_data[pick_idx];
        end else begin
          // hold saturated, nobody waiting
          data_d = src_data[owner_q];
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = |grant_d;
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.disp_data = data_q;

endmodule

// File: tb/tb_seg_arbiter.sv
// Directed self-checking bench for seg_arbiter (N_REQ=4, HOLD_CYC=4).
module tb_seg_arbiter;
  import seg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0]       req = '0;
  logic [3:0][31:0] rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seg_arbiter_if #(.N_REQ(4)) bus ();
  assign bus.req      = req;
  assign bus.req_data = rd;

  seg_arbiter #(.CLK_FREQ(1000), .N_REQ(4), .HOLD_MS(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]  req;
    logic [31:0] d2;
    logic [3:0]  g;
    logic [1:0]  o;
    logic        b;
    logic [31:0] d;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("onehot0", 32'($onehot0(bus.grant)), 32'd1);
  endtask

  task automatic expect_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                            input logic b, input logic [31:0] d);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".owner"}, 32'(bus.owner), 32'(o));
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".data"},  bus.disp_data,  d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rd[0] = 32'h1000_0000;
    rd[1] = 32'h1111_1111;
    rd[2] = 32'h2222_2222;
    rd[3] = 32'h3333_3333;

    // req, data of source 2, expected grant/owner/busy/disp_data
    vecs[0]  = '{4'b0100, 32'hDEAD_BEEF, 4'b0100, 2'd2, 1'b1, 32'hDEAD_BEEF};
    vecs[1]  = '{4'b0100, 32'h1234_5678, 4'b0100, 2'd2, 1'b1, 32'h1234_5678};
    vecs[2]  = '{4'b0100, 32'h1234_5678, 4'b0100, 2'd2, 1'b1, 32'h1234_5678};
    vecs[3]  = '{4'b0000, 32'h1234_5678, 4'b0000, 2'd2, 1'b0, 32'h1234_5678};
    vecs[4]  = '{4'b0000, 32'h1234_5678, 4'b0000, 2'd2, 1'b0, 32'h1234_5678};
    vecs[5]  = '{4'b0011, 32'h1234_5678, 4'b0001, 2'd0, 1'b1, 32'h1000_0000};
    vecs[6]  = '{4'b0011, 32'h1234_5678, 4'b0001, 2'd0, 1'b1, 32'h1000_0000};
    vecs[7]  = '{4'b0011, 32'h1234_5678, 4'b0001, 2'd0, 1'b1, 32'h1000_0000};
    vecs[8]  = '{4'b0011, 32'h1234_5678, 4'b0001, 2'd0, 1'b1, 32'h1000_0000};
    vecs[9]  = '{4'b0011, 32'h1234_5678, 4'b0010, 2'd1, 1'b1, 32'h1111_1111};
    vecs[10] = '{4'b0001, 32'h1234_5678, 4'b0000, 2'd1, 1'b0, 32'h1111_1111};
    vecs[11] = '{4'b0001, 32'h1234_5678, 4'b0001, 2'd0, 1'b1, 32'h1000_0000};

    // reset state and quiet idle
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      expect_all("idle", 4'b0000, 2'd0, 1'b0, 32'h0);
    end

    // table: first grant, live data, release, wrap search, handover, re-grant
    for (int i = 0; i < 12; i++) begin
      req   = vecs[i].req;
      rd[2] = vecs[i].d2;
      step();
      expect_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].o, vecs[i].b, vecs[i].d);
    end

    // full contention: each source owns exactly 4 cycles, rotating
    rd[2] = 32'h2222_2222;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      logic [1:0] who;
      who = 2'((k / 4) % 4);
      step();
      chk($sformatf("rr%0d.grant", k), 32'(bus.grant), 32'(4'b0001 << who));
      chk($sformatf("rr%0d.data", k), bus.disp_data, rd[who]);
    end

    // competitor arrives at hold_cnt=1: no preemption before expiry
    do_reset();
    req = 4'b0001;
    step();
    chk("late.g0", 32'(bus.grant), 32'(4'b0001));
    step();
    req = 4'b0011;
    step();
    chk("late.g2", 32'(bus.grant), 32'(4'b0001));
    step();
    chk("late.g3", 32'(bus.grant), 32'(4'b0001));
    step();
    expect_all("late.ho", 4'b0010, 2'd1, 1'b1, 32'h1111_1111);

    // owner 3 drops early; pointer wrapped to 0
    do_reset();
    req = 4'b1000;
    step();
    step();
    expect_all("drop.own", 4'b1000, 2'd3, 1'b1, 32'h3333_3333);
    req = 4'b0000;
    step();
    expect_all("drop.rel", 4'b0000, 2'd3, 1'b0, 32'h3333_3333);
    req = 4'b1001;
    step();
    expect_all("drop.new", 4'b0001, 2'd0, 1'b1, 32'h1000_0000);

    // long sole ownership saturates, then immediate handover
    do_reset();
    req = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      if (k == 10) rd[0] = 32'hCAFE_F00D;
      step();
      chk($sformatf("sole%0d.grant", k), 32'(bus.grant), 32'(4'b0001));
    end
    chk("sole.live", bus.disp_data, 32'hCAFE_F00D);
    req = 4'b0101;
    step();
    expect_all("sole.ho", 4'b0100, 2'd2, 1'b1, 32'h2222_2222);

    // reset mid-ownership wins over a held request
    do_reset();
    req = 4'b0010;
    step();
    step();
    expect_all("rst.own", 4'b0010, 2'd1, 1'b1, 32'h1111_1111);
    rst = 1'b1;
    step();
    expect_all("rst.mid", 4'b0000, 2'd0, 1'b0, 32'h0);
    rst = 1'b0;
    step();
    expect_all("rst.after", 4'b0010, 2'd1, 1'b1, 32'h1111_1111);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_arbiter.md
# seg_arbiter

Shares the single eight-digit seven-segment display between up to N_REQ requesters, for example CPU MMIO, debug PC trace and switch echo. It grants exclusive ownership round-robin and enforces a minimum ownership time so every source stays readable. Its 32-bit `disp_data` output drives the `data` input of the existing seven-segment scan driver.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `HOLD_MS`, 500: minimum ownership time in ms. HOLD_CYC = HOLD_MS*(CLK_FREQ/1000) cycles; must be ≥1.
- `CLK`  in  1: the only clock; all logic on posedge.
- `RST`  in  1: synchronous, active-high reset.
- `req`  in  N_REQ: per-requester level request; bit i means source i wants the display.
- `req_data`  in  32*N_REQ: source i supplies its 8 hex digits on bits [32*i+31 -: 32].
- `grant`  out  N_REQ: one-hot current owner; all zeros when idle. Registered.
- `owner`  out  clog2(N_REQ): index of the current or last owner. Registered.
- `busy`  out  1: equals |grant. Registered.
- `disp_data`  out  32: value to display; holds the last owner's data when idle. Registered.

## Operation
- States:
  - IDLE: no owner.
  - OWN: `grant[owner]` is high and `hold_cnt` runs.
- Round-robin pointer `ptr` (clog2(N_REQ) bits):
  - Search order is ptr, ptr+1, …, wrapping mod N_REQ.
  - On every new grant to index g, ptr <= (g+1) mod N_REQ.
- IDLE:
  - If req≠0, pick the first set bit in search order.
  - Next cycle: grant=onehot(g), owner=g, disp_data=req_data[g], hold_cnt=0, state OWN.
  - If req=0, remain in IDLE; all outputs hold.
- OWN, evaluated each cycle with owner g:
  - req[g]=0, early release: next cycle grant=0, state IDLE. disp_data keeps its last value. ptr is already g+1.
  - req[g]=1 and hold_cnt<HOLD_CYC-1: disp_data<=req_data[g] (live update); hold_cnt++.
  - req[g]=1, hold_cnt==HOLD_CYC-1, and some req[j]=1 with j≠g: hand over directly, with no idle cycle, to the first such j in search order from ptr. Reload disp_data and hold_cnt=0.
  - req[g]=1, hold_cnt==HOLD_CYC-1, and no other request: keep ownership and live updates. hold_cnt saturates, so a later competing request causes a handover on the next cycle.
- Requests from non-owners never preempt before the hold expires.
- Requests may drop at any time without penalty.
- Reset, including mid-ownership:
  - state=IDLE, grant=0, busy=0, owner=0, ptr=0, hold_cnt=0, disp_data=32'h0000_0000.
  - Reset takes priority over every other event in the same cycle.

## Timing
- Arbitration latency: request sampled at edge t in IDLE gives grant and disp_data valid after edge t+1 (1 cycle).
- Release: req[g] low at edge t gives grant=0 after t+1. The earliest new grant appears after t+2.
- Handover at hold expiry: old grant falls and new grant rises on the same edge; grant is never multi-hot.
- Live data: a req_data change at edge t appears on disp_data after t+1 while owned.
- Minimum ownership under contention is exactly HOLD_CYC cycles of grant high, counting from the first cycle grant is asserted.
- hold_cnt width is 32 bits; no wrap is possible because it saturates.

## Structure
- Shared package `seg_pkg`:
  - State enum {IDLE, OWN}.
  - Default N_REQ and HOLD_MS localparams.
  - Function computing HOLD_CYC from CLK_FREQ and HOLD_MS.
- One sub-module, `seg_rr_pick`: purely combinational.
  - Inputs: req, ptr, and an exclude-mask (the current owner during handover).
  - Outputs: found and index.
  - Used for both IDLE arbitration and handover.
- Top level holds the state register, hold counter, pointer and output registers.

## Test plan
All scenarios use CLK_FREQ=1000 and HOLD_MS=4, so HOLD_CYC=4, and N_REQ=4.
- Reset, then req=4'b0000 → grant=0, busy=0, disp_data=0 for 10 cycles.
- req=4'b0100 with req_data[2]=32'hDEAD_BEEF at edge t → grant=4'b0100, owner=2, disp_data=DEADBEEF after t+1. Change data to 32'h1234_5678 → visible 1 cycle later.
- req=4'b1111 held continuously → grant sequence 0001, 0010, 0100, 1000, 0001, each high for exactly 4 cycles, with no gaps and never multi-hot.
- Owner 0 is granted and req[1] rises at hold_cnt=1 → grant stays 0001 until 4 cycles have elapsed, then switches directly to 0010.
- Owner 3 drops req after 2 cycles while req=0 elsewhere → grant=0 the next cycle, disp_data holds, ptr=0. Then req=4'b1001 → grant=0001.
- Sole owner holds for 20 cycles, then req[2] rises → handover to 0100 on the next edge. A separate run asserts RST mid-OWN → all outputs are at reset values after that edge.
